// File: rtl/axi_stream_pkg.sv
// Shared definitions for the AXI-stream width converters.
//
// Contents:
//   USER_MODE_ALL / USER_MODE_LAST : tuser placement modes.
//   KEEP_MAX                       : widest tkeep the helper functions accept.
//   clog2()                        : ceiling log2, minimum result 0.
//   highest_nonzero_slice()        : index of the highest non-zero slice of a
//                                    keep vector cut into sliceWidth-bit slices.
package axi_stream_pkg;

    localparam string USER_MODE_ALL  = "ALL";
    localparam string USER_MODE_LAST = "LAST";

    localparam int KEEP_MAX = 256;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Returns 0 when every slice is zero, so callers must test for an empty
    // keep separately.
    function automatic int highest_nonzero_slice(
        input logic [KEEP_MAX-1:0] keep,
        input int                  sliceWidth,
        input int                  sliceCount
    );
        logic [KEEP_MAX-1:0] mask;
        int                  highest;
        mask    = (KEEP_MAX'(1) << sliceWidth) - KEEP_MAX'(1);
        highest = 0;
        for (int s = 0; s < sliceCount; s++) begin
            if (((keep >> (s * sliceWidth)) & mask) != '0) begin
                highest = s;
            end
        end
        return highest;
    endfunction

endpackage

// File: rtl/axi_stream_width_downconverter.sv
// AXI-stream width downconverter: each wide input beat is split into RATIO
// narrow output beats, lowest byte lanes first. Sub-words with an all-zero
// keep slice are skipped and tlast rides on the last populated sub-word.
// A beat whose keep is entirely zero is dropped unless it carries tlast, in
// which case a single keep=0 sub-word is emitted to terminate the frame.
//
// Ports:
//   sysClk            clock, rising edge
//   resetN            synchronous active-low reset
//   sAxiStreamT*      wide input stream (tdata, tkeep, tuser, tlast, tvalid, tready)
//   mAxiStreamT*      narrow output stream (tdata, tkeep, tuser, tlast, tvalid, tready)
//   frameCount        number of output beats handshaken with tlast, wraps
module axi_stream_width_downconverter
    import axi_stream_pkg::*;
#(
    parameter int    OUT_BYTES  = 4,
    parameter int    RATIO      = 2,
    parameter int    USER_WIDTH = 8,
    parameter string USER_MODE  = USER_MODE_ALL
) (
    input  logic                           sysClk,
    input  logic                           resetN,
    input  logic [8*OUT_BYTES*RATIO-1:0]   sAxiStreamTdata,
    input  logic [OUT_BYTES*RATIO-1:0]     sAxiStreamTkeep,
    input  logic [USER_WIDTH-1:0]          sAxiStreamTuser,
    input  logic                           sAxiStreamTlast,
    input  logic                           sAxiStreamTvalid,
    output logic                           sAxiStreamTready,
    output logic [8*OUT_BYTES-1:0]         mAxiStreamTdata,
    output logic [OUT_BYTES-1:0]           mAxiStreamTkeep,
    output logic [USER_WIDTH-1:0]          mAxiStreamTuser,
    output logic                           mAxiStreamTlast,
    output logic                           mAxiStreamTvalid,
    input  logic                           mAxiStreamTready,
    output logic [31:0]                    frameCount
);

    localparam int  OUT_W     = 8 * OUT_BYTES;
    localparam int  IN_BYTES  = OUT_BYTES * RATIO;
    localparam int  IN_W      = 8 * IN_BYTES;
    localparam int  IDX_W     = clog2(RATIO);
    localparam bit  LAST_MODE = (USER_MODE == USER_MODE_LAST);

    if (RATIO < 2) begin : gRatioCheck
        $error("RATIO must be at least 2");
    end
    if ((USER_MODE != USER_MODE_ALL) && (USER_MODE != USER_MODE_LAST)) begin : gModeCheck
        $error("USER_MODE must be \"ALL\" or \"LAST\"");
    end
    if (IN_BYTES > KEEP_MAX) begin : gKeepCheck
        $error("OUT_BYTES*RATIO exceeds KEEP_MAX");
    end

    // Holding register: one wide beat plus the sub-word cursor.
    logic [IN_W-1:0]       heldData_p0;
    logic [IN_BYTES-1:0]   heldKeep_p0;
    logic [USER_WIDTH-1:0] heldUser_p0;
    logic                  heldLast_p0;
    logic [IDX_W-1:0]      idx_p0;
    logic [IDX_W-1:0]      lastIdx_p0;
    logic                  vld_p0;

    logic [IDX_W-1:0]      loadLastIdx;
    logic                  loadKeepAny;
    logic                  atLast;
    logic                  sAccept;
    logic                  mHandshake;
    logic                  lastOut;
    logic [IDX_W-1:0]      nextIdx;
    logic [OUT_W-1:0]      subData;
    logic [OUT_BYTES-1:0]  subKeep;

    assign loadLastIdx = IDX_W'(highest_nonzero_slice(KEEP_MAX'(sAxiStreamTkeep), OUT_BYTES, RATIO));
    assign loadKeepAny = |sAxiStreamTkeep;
    assign atLast      = (idx_p0 == lastIdx_p0);
    assign sAccept     = sAxiStreamTvalid & sAxiStreamTready;
    assign mHandshake  = vld_p0 & mAxiStreamTready;
    assign lastOut     = heldLast_p0 & atLast;

    // A finishing sub-word frees the register in the same cycle it is taken,
    // so a new beat can be loaded without a bubble.
    assign sAxiStreamTready = ~vld_p0 | (mAxiStreamTready & atLast);

    // Next populated sub-word above the current one. Keep is expected to be
    // LSB-packed, but the search does not rely on it.
    always_comb begin
        nextIdx = lastIdx_p0;
        for (int k = RATIO - 1; k >= 0; k--) begin
            if ((k > int'(idx_p0)) && (heldKeep_p0[k*OUT_BYTES +: OUT_BYTES] != '0)) begin
                nextIdx = IDX_W'(k);
            end
        end
    end

    always_comb begin
        subData = '0;
        subKeep = '0;
        for (int k = 0; k < RATIO; k++) begin
            if (idx_p0 == IDX_W'(k)) begin
                subData = heldData_p0[k*OUT_W +: OUT_W];
                subKeep = heldKeep_p0[k*OUT_BYTES +: OUT_BYTES];
            end
        end
    end

    assign mAxiStreamTdata  = subData;
    assign mAxiStreamTkeep  = subKeep;
    assign mAxiStreamTlast  = lastOut;
    assign mAxiStreamTvalid = vld_p0;

    if (LAST_MODE) begin : gUserLast
        assign mAxiStreamTuser = lastOut ? heldUser_p0 : '0;
    end else begin : gUserAll
        assign mAxiStreamTuser = heldUser_p0;
    end

    // Stage p0: load / advance the holding register.
    always_ff @(posedge sysClk) begin
        if (!resetN) begin
            heldData_p0 <= '0;
            heldKeep_p0 <= '0;
            heldUser_p0 <= '0;
            heldLast_p0 <= 1'b0;
            idx_p0      <= '0;
            lastIdx_p0  <= '0;
            vld_p0      <= 1'b0;
            frameCount  <= 32'd0;
        end else begin
            if (sAccept) begin
                // An empty beat without tlast carries nothing worth emitting.
                if (loadKeepAny | sAxiStreamTlast) begin
                    heldData_p0 <= sAxiStreamTdata;
                    heldKeep_p0 <= sAxiStreamTkeep;
                    heldUser_p0 <= sAxiStreamTuser;
                    heldLast_p0 <= sAxiStreamTlast;
                    idx_p0      <= '0;
                    lastIdx_p0  <= loadLastIdx;
                    vld_p0      <= 1'b1;
                end else begin
                    vld_p0      <= 1'b0;
                end
            end else if (mHandshake) begin
                if (atLast) begin
                    vld_p0 <= 1'b0;
                end else begin
                    idx_p0 <= nextIdx;
                end
            end

            if (mHandshake & lastOut) begin
                frameCount <= frameCount + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_axi_stream_width_downconverter.sv
module tb_axi_stream_width_downconverter;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  k;
        logic [7:0]  u;
        logic        l;
    } beat0_t;

    typedef struct packed {
        logic [15:0] d;
        logic [1:0]  k;
        logic [7:0]  u;
        logic        l;
    } beat1_t;

    logic sysClk = 1'b0;
    always #5 sysClk = ~sysClk;

    logic        resetN;

    logic [63:0] s0Data;
    logic [7:0]  s0Keep;
    logic [7:0]  s0User;
    logic        s0Last, s0Valid, s0Ready;
    logic [31:0] m0Data;
    logic [3:0]  m0Keep;
    logic [7:0]  m0User;
    logic        m0Last, m0Valid, m0Ready;
    logic [31:0] fc0;

    logic [63:0] s1Data;
    logic [7:0]  s1Keep;
    logic [7:0]  s1User;
    logic        s1Last, s1Valid, s1Ready;
    logic [15:0] m1Data;
    logic [1:0]  m1Keep;
    logic [7:0]  m1User;
    logic        m1Last, m1Valid, m1Ready;
    logic [31:0] fc1;

    int checks   = 0;
    int failures = 0;

    beat0_t exp0[$];
    beat0_t obs0[$];
    beat1_t exp1[$];
    beat1_t obs1[$];
    int unsigned expFc0 = 0;
    int unsigned expFc1 = 0;

    int     stabErr0 = 0;
    int     rdyErr0  = 0;
    logic   stalled0 = 1'b0;
    beat0_t prev0;
    beat0_t cur0;
    beat1_t cur1;
    bit     sendDone;

    assign cur0 = {m0Data, m0Keep, m0User, m0Last};
    assign cur1 = {m1Data, m1Keep, m1User, m1Last};

    axi_stream_width_downconverter #(
        .OUT_BYTES(4), .RATIO(2), .USER_WIDTH(8), .USER_MODE("ALL")
    ) dut0 (
        .sysClk(sysClk), .resetN(resetN),
        .sAxiStreamTdata(s0Data), .sAxiStreamTkeep(s0Keep), .sAxiStreamTuser(s0User),
        .sAxiStreamTlast(s0Last), .sAxiStreamTvalid(s0Valid), .sAxiStreamTready(s0Ready),
        .mAxiStreamTdata(m0Data), .mAxiStreamTkeep(m0Keep), .mAxiStreamTuser(m0User),
        .mAxiStreamTlast(m0Last), .mAxiStreamTvalid(m0Valid), .mAxiStreamTready(m0Ready),
        .frameCount(fc0)
    );

    axi_stream_width_downconverter #(
        .OUT_BYTES(2), .RATIO(4), .USER_WIDTH(8), .USER_MODE("LAST")
    ) dut1 (
        .sysClk(sysClk), .resetN(resetN),
        .sAxiStreamTdata(s1Data), .sAxiStreamTkeep(s1Keep), .sAxiStreamTuser(s1User),
        .sAxiStreamTlast(s1Last), .sAxiStreamTvalid(s1Valid), .sAxiStreamTready(s1Ready),
        .mAxiStreamTdata(m1Data), .mAxiStreamTkeep(m1Keep), .mAxiStreamTuser(m1User),
        .mAxiStreamTlast(m1Last), .mAxiStreamTvalid(m1Valid), .mAxiStreamTready(m1Ready),
        .frameCount(fc1)
    );

    // Output monitors: collect handshaken beats, watch stall stability and
    // that no input is taken while the output is stalled.
    always @(negedge sysClk) begin
        if (!resetN) begin
            stalled0 = 1'b0;
        end else begin
            if (stalled0 && (!m0Valid || (cur0 !== prev0))) stabErr0++;
            if (m0Valid && !m0Ready && s0Ready) rdyErr0++;
            stalled0 = m0Valid && !m0Ready;
            prev0    = cur0;
            if (m0Valid && m0Ready) obs0.push_back(cur0);
        end
    end

    always @(negedge sysClk) begin
        if (resetN && m1Valid && m1Ready) obs1.push_back(cur1);
    end

    // Reference model, RATIO=2 / 4-byte sub-words / tuser on every beat.
    task automatic model0(input logic [63:0] d, input logic [7:0] k,
                          input logic [7:0] u, input logic l);
        int     hi;
        beat0_t b;
        hi = -1;
        for (int s = 0; s < 2; s++) if (k[s*4 +: 4] != 4'h0) hi = s;
        if (hi < 0) begin
            if (l) begin
                b = {d[31:0], 4'h0, u, 1'b1};
                exp0.push_back(b);
                expFc0++;
            end
        end else begin
            for (int s = 0; s <= hi; s++) begin
                if (k[s*4 +: 4] != 4'h0) begin
                    b = {d[s*32 +: 32], k[s*4 +: 4], u, (l && s == hi)};
                    exp0.push_back(b);
                    if (l && s == hi) expFc0++;
                end
            end
        end
    endtask

    // Reference model, RATIO=4 / 2-byte sub-words / tuser on tlast only.
    task automatic model1(input logic [63:0] d, input logic [7:0] k,
                          input logic [7:0] u, input logic l);
        int     hi;
        beat1_t b;
        hi = -1;
        for (int s = 0; s < 4; s++) if (k[s*2 +: 2] != 2'b00) hi = s;
        if (hi < 0) begin
            if (l) begin
                b = {d[15:0], 2'b00, u, 1'b1};
                exp1.push_back(b);
                expFc1++;
            end
        end else begin
            for (int s = 0; s <= hi; s++) begin
                if (k[s*2 +: 2] != 2'b00) begin
                    b = {d[s*16 +: 16], k[s*2 +: 2], ((l && s == hi) ? u : 8'h00), (l && s == hi)};
                    exp1.push_back(b);
                    if (l && s == hi) expFc1++;
                end
            end
        end
    endtask

    task automatic sendBeat0(input logic [63:0] d, input logic [7:0] k,
                             input logic [7:0] u, input logic l);
        int n;
        bit acc;
        n   = 0;
        acc = 1'b0;
        model0(d, k, u, l);
        s0Data = d; s0Keep = k; s0User = u; s0Last = l; s0Valid = 1'b1;
        while (!acc && n < 200) begin
            @(negedge sysClk);
            acc = s0Ready;
            @(posedge sysClk);
            #1;
            n++;
        end
        s0Valid = 1'b0;
        if (!acc) begin
            checks++; failures++;
            $display("FAIL send0_timeout accepted=%0b required=1", acc);
        end
    endtask

    task automatic sendBeat1(input logic [63:0] d, input logic [7:0] k,
                             input logic [7:0] u, input logic l);
        int n;
        bit acc;
        n   = 0;
        acc = 1'b0;
        model1(d, k, u, l);
        s1Data = d; s1Keep = k; s1User = u; s1Last = l; s1Valid = 1'b1;
        while (!acc && n < 200) begin
            @(negedge sysClk);
            acc = s1Ready;
            @(posedge sysClk);
            #1;
            n++;
        end
        s1Valid = 1'b0;
        if (!acc) begin
            checks++; failures++;
            $display("FAIL send1_timeout accepted=%0b required=1", acc);
        end
    endtask

    task automatic waitObs0(input int want);
        int n;
        n = 0;
        while (obs0.size() < want && n < 400) begin
            @(posedge sysClk); #1; n++;
        end
        repeat (3) begin @(posedge sysClk); #1; end
    endtask

    task automatic waitObs1(input int want);
        int n;
        n = 0;
        while (obs1.size() < want && n < 400) begin
            @(posedge sysClk); #1; n++;
        end
        repeat (3) begin @(posedge sysClk); #1; end
    endtask

    function automatic logic [7:0] packedKeep(input int nBytes);
        logic [15:0] wide;
        wide = (16'd1 << nBytes) - 16'd1;
        return wide[7:0];
    endfunction

    task automatic test_reset();
        resetN = 1'b0;
        repeat (3) @(posedge sysClk);
        #1;
        resetN = 1'b1;
        expFc0 = 0;
        expFc1 = 0;
        checks++;
        if ({m0Valid, m0Last, m0Data, m0Keep, m0User} !== 46'd0) begin
            failures++;
            $display("FAIL reset_outputs0 got=%h required=0", {m0Valid, m0Last, m0Data, m0Keep, m0User});
        end
        checks++;
        if (s0Ready !== 1'b1) begin
            failures++; $display("FAIL reset_ready0 got=%b required=1", s0Ready);
        end
        checks++;
        if (fc0 !== 32'd0) begin
            failures++; $display("FAIL reset_fc0 got=%0d required=0", fc0);
        end
        checks++;
        if ({m1Valid, m1Last, m1Data, m1Keep, m1User, s1Ready, fc1} !== {28'd0, 1'b1, 32'd0}) begin
            failures++;
            $display("FAIL reset_dut1 valid=%b last=%b data=%h keep=%h user=%h ready=%b fc=%0d required valid=0 ready=1 rest=0",
                     m1Valid, m1Last, m1Data, m1Keep, m1User, s1Ready, fc1);
        end
    endtask

    task automatic test_defaults();
        int ob;
        ob = obs0.size();
        m0Ready = 1'b1;
        sendBeat0(64'h1111_2222_3333_4444, 8'hFF, 8'h5A, 1'b1);
        checks++;
        if (m0Valid !== 1'b1 || m0Data !== 32'h3333_4444) begin
            failures++;
            $display("FAIL defaults_latency valid=%b data=%h required valid=1 data=33334444", m0Valid, m0Data);
        end
        waitObs0(ob + 2);
        checks++;
        if (obs0.size() !== ob + 2) begin
            failures++; $display("FAIL defaults_count got=%0d required=%0d", obs0.size() - ob, 2);
        end else begin
            checks++;
            if (obs0[ob] !== {32'h3333_4444, 4'hF, 8'h5A, 1'b0}) begin
                failures++; $display("FAIL defaults_beat0 got=%h required=%h", obs0[ob], {32'h3333_4444, 4'hF, 8'h5A, 1'b0});
            end
            checks++;
            if (obs0[ob+1] !== {32'h1111_2222, 4'hF, 8'h5A, 1'b1}) begin
                failures++; $display("FAIL defaults_beat1 got=%h required=%h", obs0[ob+1], {32'h1111_2222, 4'hF, 8'h5A, 1'b1});
            end
        end
        checks++;
        if (fc0 !== 32'd1) begin
            failures++; $display("FAIL defaults_fc got=%0d required=1", fc0);
        end
    endtask

    task automatic test_partial();
        int          ob, eb;
        logic [63:0] d;
        ob = obs0.size();
        eb = exp0.size();
        d  = {$urandom, $urandom};
        m0Ready = 1'b1;
        sendBeat0(d, 8'h0F, 8'h3C, 1'b1);
        checks++;
        if ({m0Valid, m0Keep, m0Last, s0Ready} !== {1'b1, 4'hF, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL partial_present valid=%b keep=%h last=%b ready=%b required 1 f 1 1", m0Valid, m0Keep, m0Last, s0Ready);
        end
        waitObs0(ob + 1);
        checks++;
        if (obs0.size() !== ob + 1 || obs0[ob] !== exp0[eb]) begin
            failures++; $display("FAIL partial_beat count=%0d got=%h required=%h", obs0.size() - ob, cur0, exp0[eb]);
        end
        checks++;
        if (fc0 !== expFc0) begin
            failures++; $display("FAIL partial_fc got=%0d required=%0d", fc0, expFc0);
        end
    endtask

    task automatic test_zero_keep();
        int          ob, eb;
        logic [63:0] d;
        ob = obs0.size();
        d  = {$urandom, $urandom};
        m0Ready = 1'b1;
        sendBeat0(d, 8'h00, 8'h11, 1'b0);
        repeat (3) begin @(posedge sysClk); #1; end
        checks++;
        if (obs0.size() !== ob || m0Valid !== 1'b0) begin
            failures++; $display("FAIL zero_nolast count=%0d valid=%b required count=0 valid=0", obs0.size() - ob, m0Valid);
        end
        eb = exp0.size();
        d  = {$urandom, $urandom};
        sendBeat0(d, 8'h00, 8'h22, 1'b1);
        waitObs0(ob + 1);
        checks++;
        if (obs0.size() !== ob + 1 || obs0[ob] !== {d[31:0], 4'h0, 8'h22, 1'b1}) begin
            failures++;
            $display("FAIL zero_last count=%0d got=%h required=%h", obs0.size() - ob, cur0, {d[31:0], 4'h0, 8'h22, 1'b1});
        end
        checks++;
        if (exp0.size() !== eb + 1 || fc0 !== expFc0) begin
            failures++; $display("FAIL zero_fc got=%0d required=%0d", fc0, expFc0);
        end
    endtask

    task automatic test_backpressure();
        int ob, eb, se, re;
        bit pat[4];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        ob = obs0.size(); eb = exp0.size(); se = stabErr0; re = rdyErr0;
        fork
            begin
                for (int i = 0; i < 3; i++)
                    sendBeat0({$urandom, $urandom}, 8'hFF, 8'($urandom), (i == 2));
            end
            begin
                for (int c = 0; c < 12; c++) begin
                    m0Ready = pat[c % 4];
                    @(posedge sysClk); #1;
                end
            end
        join
        m0Ready = 1'b1;
        waitObs0(ob + 6);
        checks++;
        if (obs0.size() !== ob + 6) begin
            failures++; $display("FAIL bp_count got=%0d required=6", obs0.size() - ob);
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (obs0[ob+i] !== exp0[eb+i]) begin
                    failures++; $display("FAIL bp_beat%0d got=%h required=%h", i, obs0[ob+i], exp0[eb+i]);
                end
            end
        end
        checks++;
        if (stabErr0 !== se) begin
            failures++; $display("FAIL bp_stable violations=%0d required=0", stabErr0 - se);
        end
        checks++;
        if (rdyErr0 !== re) begin
            failures++; $display("FAIL bp_ready_while_stalled events=%0d required=0", rdyErr0 - re);
        end
    endtask

    task automatic test_back_to_back();
        int ob, eb, se, re, nExp;
        ob = obs0.size(); eb = exp0.size(); se = stabErr0; re = rdyErr0;
        sendDone = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++)
                    sendBeat0({$urandom, $urandom}, packedKeep($urandom_range(0, 8)),
                              8'($urandom), ($urandom_range(0, 2) == 0));
                sendBeat0({$urandom, $urandom}, 8'hFF, 8'($urandom), 1'b1);
                sendDone = 1'b1;
            end
            begin
                while (!sendDone) begin
                    m0Ready = ($urandom_range(0, 3) != 0);
                    @(posedge sysClk); #1;
                end
            end
        join
        m0Ready = 1'b1;
        nExp = exp0.size() - eb;
        waitObs0(ob + nExp);
        checks++;
        if (obs0.size() !== ob + nExp) begin
            failures++; $display("FAIL b2b_count got=%0d required=%0d", obs0.size() - ob, nExp);
        end else begin
            for (int i = 0; i < nExp; i++) begin
                checks++;
                if (obs0[ob+i] !== exp0[eb+i]) begin
                    failures++; $display("FAIL b2b_beat%0d got=%h required=%h", i, obs0[ob+i], exp0[eb+i]);
                end
            end
        end
        checks++;
        if (stabErr0 !== se || rdyErr0 !== re) begin
            failures++; $display("FAIL b2b_protocol stable=%0d ready=%0d required 0 0", stabErr0 - se, rdyErr0 - re);
        end
        checks++;
        if (fc0 !== expFc0) begin
            failures++; $display("FAIL b2b_fc got=%0d required=%0d", fc0, expFc0);
        end
    endtask

    task automatic test_user_last();
        int          ob, eb, nExp;
        logic [63:0] d;
        ob = obs1.size();
        d  = {$urandom, $urandom};
        m1Ready = 1'b1;
        sendBeat1(d, 8'h3F, 8'hA5, 1'b1);
        waitObs1(ob + 3);
        checks++;
        if (obs1.size() !== ob + 3) begin
            failures++; $display("FAIL ulast_count got=%0d required=3", obs1.size() - ob);
        end else begin
            checks++;
            if (obs1[ob] !== {d[15:0], 2'b11, 8'h00, 1'b0}) begin
                failures++; $display("FAIL ulast_beat0 got=%h required=%h", obs1[ob], {d[15:0], 2'b11, 8'h00, 1'b0});
            end
            checks++;
            if (obs1[ob+1] !== {d[31:16], 2'b11, 8'h00, 1'b0}) begin
                failures++; $display("FAIL ulast_beat1 got=%h required=%h", obs1[ob+1], {d[31:16], 2'b11, 8'h00, 1'b0});
            end
            checks++;
            if (obs1[ob+2] !== {d[47:32], 2'b11, 8'hA5, 1'b1}) begin
                failures++; $display("FAIL ulast_beat2 got=%h required=%h", obs1[ob+2], {d[47:32], 2'b11, 8'hA5, 1'b1});
            end
        end

        ob = obs1.size();
        eb = exp1.size();
        sendDone = 1'b0;
        fork
            begin
                for (int i = 0; i < 24; i++)
                    sendBeat1({$urandom, $urandom}, packedKeep($urandom_range(0, 8)),
                              8'($urandom), ($urandom_range(0, 1) == 0));
                sendDone = 1'b1;
            end
            begin
                while (!sendDone) begin
                    m1Ready = ($urandom_range(0, 2) != 0);
                    @(posedge sysClk); #1;
                end
            end
        join
        m1Ready = 1'b1;
        nExp = exp1.size() - eb;
        waitObs1(ob + nExp);
        checks++;
        if (obs1.size() !== ob + nExp) begin
            failures++; $display("FAIL ulast_rand_count got=%0d required=%0d", obs1.size() - ob, nExp);
        end else begin
            for (int i = 0; i < nExp; i++) begin
                checks++;
                if (obs1[ob+i] !== exp1[eb+i]) begin
                    failures++; $display("FAIL ulast_rand_beat%0d got=%h required=%h", i, obs1[ob+i], exp1[eb+i]);
                end
            end
        end
        checks++;
        if (fc1 !== expFc1) begin
            failures++; $display("FAIL ulast_fc got=%0d required=%0d", fc1, expFc1);
        end
    endtask

    task automatic test_reset_mid_beat();
        int          ob, eb;
        logic [63:0] d;
        ob = obs0.size();
        eb = exp0.size();
        m0Ready = 1'b1;
        sendBeat0({$urandom, $urandom}, 8'hFF, 8'h77, 1'b1);
        @(posedge sysClk); #1;
        resetN = 1'b0;
        @(posedge sysClk); #1;
        checks++;
        if (obs0.size() !== ob + 1 || obs0[ob] !== exp0[eb]) begin
            failures++; $display("FAIL midreset_first count=%0d required=1", obs0.size() - ob);
        end
        checks++;
        if ({m0Valid, m0Last, m0Data, m0Keep, m0User} !== 46'd0) begin
            failures++;
            $display("FAIL midreset_outputs got=%h required=0", {m0Valid, m0Last, m0Data, m0Keep, m0User});
        end
        checks++;
        if (s0Ready !== 1'b1 || fc0 !== 32'd0) begin
            failures++; $display("FAIL midreset_ready_fc ready=%b fc=%0d required ready=1 fc=0", s0Ready, fc0);
        end
        resetN = 1'b1;
        expFc0 = 0;
        repeat (2) begin @(posedge sysClk); #1; end
        checks++;
        if (obs0.size() !== ob + 1) begin
            failures++; $display("FAIL midreset_dropped extra=%0d required=0", obs0.size() - ob - 1);
        end
        ob = obs0.size();
        eb = exp0.size();
        d  = {$urandom, $urandom};
        sendBeat0(d, 8'hFF, 8'h99, 1'b1);
        waitObs0(ob + 2);
        checks++;
        if (obs0.size() !== ob + 2 || obs0[ob] !== exp0[eb] || obs0[ob+1] !== exp0[eb+1]) begin
            failures++; $display("FAIL midreset_next count=%0d last=%h required=%h", obs0.size() - ob, cur0, exp0[eb+1]);
        end
        checks++;
        if (fc0 !== 32'd1) begin
            failures++; $display("FAIL midreset_fc got=%0d required=1", fc0);
        end
    endtask

    initial begin
        resetN  = 1'b0;
        s0Data  = '0; s0Keep = '0; s0User = '0; s0Last = 1'b0; s0Valid = 1'b0;
        s1Data  = '0; s1Keep = '0; s1User = '0; s1Last = 1'b0; s1Valid = 1'b0;
        m0Ready = 1'b1;
        m1Ready = 1'b1;

        test_reset();
        test_defaults();
        test_partial();
        test_zero_keep();
        test_backpressure();
        test_back_to_back();
        test_user_last();
        test_reset_mid_beat();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
